// File: rtl/countdown_pkg.sv
// Shared types and constants for the MM:SS BCD countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned BCD_W = 4;

  localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;
  localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;

  typedef struct packed {
    logic [BCD_W-1:0] m1;
    logic [BCD_W-1:0] m0;
    logic [BCD_W-1:0] s1;
    logic [BCD_W-1:0] s0;
  } bcd_time_t;

  // True when every digit of t lies inside its modulus.
  function automatic logic bcd_load_ok(input bcd_time_t t, input logic [BCD_W-1:0] m1_max);
    return (t.s0 <= DIGIT_MAX) && (t.s1 <= SEC_TENS_MAX) &&
           (t.m0 <= DIGIT_MAX) && (t.m1 <= m1_max);
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit; reloads MAX when it borrows.
module bcd_down_digit
  import countdown_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = DIGIT_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [BCD_W-1:0] load_val_i,
  output logic [BCD_W-1:0] value_o,
  output logic             borrow_o
);

  assign borrow_o = en_i & (value_o == '0);

  // Load wins over decrement; a decrement from zero wraps to MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_o <= '0;
    end else if (load_i) begin
      value_o <= load_val_i;
    end else if (en_i) begin
      value_o <= (value_o == '0) ? MAX : value_o - BCD_W'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable MM:SS BCD countdown timer with run/pause control and done pulse.
//
// state | meaning
// IDLE  | loaded or reset, waiting for start
// RUN   | decrementing one second per tick
// PAUSE | count held, start resumes
// DONE  | reached 00:00, waiting for a new load
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned MIN_TENS_MAX = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_i,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        start_i,
  input  logic        pause_i,
  output logic [15:0] time_o,
  output logic        running_o,
  output logic        done_o,
  output logic        load_err_o
);

  localparam logic [BCD_W-1:0] M1_MAX = BCD_W'(MIN_TENS_MAX);

  state_e    state;
  bcd_time_t cur;
  bcd_time_t ld;
  logic      time_zero;
  logic      at_one;
  logic      in_run;
  logic      load_ok;
  logic      load_acc;
  logic      dec_en;
  logic      b_s0, b_s1, b_m0;
  logic      borrow_m1_unused;

  assign ld        = load_val_i;
  assign time_o    = cur;
  assign time_zero = (cur == '0);
  assign at_one    = (cur == 16'h0001);
  assign in_run    = (state == RUN);
  assign load_ok   = bcd_load_ok(ld, M1_MAX);
  // Loads are not honoured while running, so a tick in RUN always counts.
  assign load_acc  = load_i & ~in_run & load_ok;
  // The zero guard keeps 00:00 from wrapping to the top of the range.
  assign dec_en    = in_run & tick_i & ~time_zero;

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_s0 (
    .clk(clk), .rst(rst), .en_i(dec_en), .load_i(load_acc),
    .load_val_i(ld.s0), .value_o(cur.s0), .borrow_o(b_s0)
  );

  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_s1 (
    .clk(clk), .rst(rst), .en_i(b_s0), .load_i(load_acc),
    .load_val_i(ld.s1), .value_o(cur.s1), .borrow_o(b_s1)
  );

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_m0 (
    .clk(clk), .rst(rst), .en_i(b_s1), .load_i(load_acc),
    .load_val_i(ld.m0), .value_o(cur.m0), .borrow_o(b_m0)
  );

  bcd_down_digit #(.MAX(M1_MAX)) u_m1 (
    .clk(clk), .rst(rst), .en_i(b_m0), .load_i(load_acc),
    .load_val_i(ld.m1), .value_o(cur.m1), .borrow_o(borrow_m1_unused)
  );

  // Control FSM with registered running/done/load-error outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      running_o  <= 1'b0;
      done_o     <= 1'b0;
      load_err_o <= 1'b0;
    end else begin
      done_o     <= 1'b0;
      load_err_o <= 1'b0;
      case (state)
        RUN: begin
          // Reaching zero outranks a simultaneous pause.
          if (dec_en && at_one) begin
            state     <= DONE;
            running_o <= 1'b0;
            done_o    <= 1'b1;
          end else if (pause_i) begin
            state     <= PAUSE;
            running_o <= 1'b0;
          end
        end
        default: begin
          if (load_i) begin
            if (load_ok) begin
              state     <= IDLE;
              running_o <= 1'b0;
            end else begin
              load_err_o <= 1'b1;
            end
          end else if (pause_i) begin
            state <= state;
          end else if (start_i && (state != DONE) && !time_zero) begin
            state     <= RUN;
            running_o <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with hand-computed expectations.
module tb_countdown_timer;

  logic        clk;
  logic        rst;
  logic        tick_i;
  logic        load_i;
  logic [15:0] load_val_i;
  logic        start_i;
  logic        pause_i;
  logic [15:0] time_o;
  logic        running_o;
  logic        done_o;
  logic        load_err_o;

  int checks;
  int errors;

  countdown_timer #(.MIN_TENS_MAX(9)) dut (
    .clk(clk),
    .rst(rst),
    .tick_i(tick_i),
    .load_i(load_i),
    .load_val_i(load_val_i),
    .start_i(start_i),
    .pause_i(pause_i),
    .time_o(time_o),
    .running_o(running_o),
    .done_o(done_o),
    .load_err_o(load_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, let the edge pass, then release them.
  task automatic step(input logic r, input logic t, input logic l,
                      input logic [15:0] v, input logic s, input logic p);
    rst = r; tick_i = t; load_i = l; load_val_i = v; start_i = s; pause_i = p;
    @(posedge clk);
    #1;
    rst = 1'b0; tick_i = 1'b0; load_i = 1'b0; load_val_i = 16'h0000;
    start_i = 1'b0; pause_i = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] t, input logic run,
                         input logic dn, input logic er);
    chk({tag, ".time"}, time_o, t);
    chk({tag, ".run"}, {15'd0, running_o}, {15'd0, run});
    chk({tag, ".done"}, {15'd0, done_o}, {15'd0, dn});
    chk({tag, ".err"}, {15'd0, load_err_o}, {15'd0, er});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0; tick_i = 1'b0; load_i = 1'b0; load_val_i = 16'h0000;
    start_i = 1'b0; pause_i = 1'b0;
    #2;

    // reset
    step(1, 0, 0, 16'h0000, 0, 0);
    chk_out("reset", 16'h0000, 0, 0, 0);

    // countdown to done
    step(0, 0, 1, 16'h0003, 0, 0);  chk_out("ld3", 16'h0003, 0, 0, 0);
    step(0, 0, 0, 16'h0000, 1, 0);  chk_out("start3", 16'h0003, 1, 0, 0);
    step(0, 1, 0, 16'h0000, 0, 0);  chk_out("t1", 16'h0002, 1, 0, 0);
    step(0, 1, 0, 16'h0000, 0, 0);  chk_out("t2", 16'h0001, 1, 0, 0);
    step(0, 1, 0, 16'h0000, 0, 0);  chk_out("t3", 16'h0000, 0, 1, 0);
    step(0, 0, 0, 16'h0000, 0, 0);  chk_out("done_drop", 16'h0000, 0, 0, 0);
    step(0, 1, 0, 16'h0000, 0, 0);  chk_out("t4_hold", 16'h0000, 0, 0, 0);
    step(0, 0, 0, 16'h0000, 1, 0);  chk_out("start_in_done", 16'h0000, 0, 0, 0);

    // multi-digit borrow
    step(0, 0, 1, 16'h1000, 0, 0);  chk_out("ld1000", 16'h1000, 0, 0, 0);
    step(0, 0, 0, 16'h0000, 1, 0);
    step(0, 1, 0, 16'h0000, 0, 0);  chk_out("b0959", 16'h0959, 1, 0, 0);
    step(0, 0, 0, 16'h0000, 0, 1);  chk_out("pause_a", 16'h0959, 0, 0, 0);
    step(0, 0, 1, 16'h0100, 0, 0);  chk_out("ld0100", 16'h0100, 0, 0, 0);
    step(0, 0, 0, 16'h0000, 1, 0);
    step(0, 1, 0, 16'h0000, 0, 0);  chk_out("b0059", 16'h0059, 1, 0, 0);

    // pause / resume
    step(0, 0, 0, 16'h0000, 0, 1);
    step(0, 0, 1, 16'h0100, 0, 0);
    step(0, 0, 0, 16'h0000, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 16'h0000, 0, 0);
    chk_out("five_ticks", 16'h0055, 1, 0, 0);
    step(0, 1, 0, 16'h0000, 0, 1);  chk_out("pause_tick", 16'h0054, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 16'h0000, 0, 0);
    chk_out("paused_hold", 16'h0054, 0, 0, 0);
    step(0, 0, 0, 16'h0000, 1, 0);  chk_out("resume", 16'h0054, 1, 0, 0);
    step(0, 1, 0, 16'h0000, 0, 0);  chk_out("resume_tick", 16'h0053, 1, 0, 0);

    // load rules
    step(0, 1, 1, 16'h0200, 0, 0);  chk_out("ld_in_run", 16'h0052, 1, 0, 0);
    step(0, 0, 0, 16'h0000, 0, 1);  chk_out("pause_b", 16'h0052, 0, 0, 0);
    step(0, 0, 1, 16'h0060, 0, 0);  chk_out("bad_s1", 16'h0052, 0, 0, 1);
    step(0, 0, 0, 16'h0000, 0, 0);  chk_out("err_drop", 16'h0052, 0, 0, 0);
    step(0, 0, 1, 16'h0A00, 0, 0);  chk_out("bad_m0", 16'h0052, 0, 0, 1);
    step(0, 0, 0, 16'h0000, 1, 0);  chk_out("resume_pause_kept", 16'h0052, 1, 0, 0);
    step(0, 0, 0, 16'h0000, 0, 1);
    step(0, 0, 1, 16'h9959, 0, 0);  chk_out("ld9959", 16'h9959, 0, 0, 0);
    step(0, 1, 0, 16'h0000, 0, 0);  chk_out("idle_tick", 16'h9959, 0, 0, 0);

    // start edges
    step(0, 0, 1, 16'h0000, 0, 0);  chk_out("ld0000", 16'h0000, 0, 0, 0);
    step(0, 0, 0, 16'h0000, 1, 0);  chk_out("start_zero", 16'h0000, 0, 0, 0);
    step(0, 0, 0, 16'h0000, 0, 0);  chk_out("start_zero_nd", 16'h0000, 0, 0, 0);
    step(0, 0, 1, 16'h0005, 0, 0);
    step(0, 1, 0, 16'h0000, 1, 0);  chk_out("start_tick", 16'h0005, 1, 0, 0);
    step(0, 1, 0, 16'h0000, 0, 0);  chk_out("first_tick", 16'h0004, 1, 0, 0);

    // held tick and tens-of-seconds borrow
    step(0, 0, 0, 16'h0000, 0, 1);
    step(0, 0, 1, 16'h0011, 0, 0);
    step(0, 0, 0, 16'h0000, 1, 0);
    step(0, 1, 0, 16'h0000, 0, 0);  chk_out("h0010", 16'h0010, 1, 0, 0);
    step(0, 1, 0, 16'h0000, 0, 0);  chk_out("h0009", 16'h0009, 1, 0, 0);
    step(0, 1, 0, 16'h0000, 0, 0);  chk_out("h0008", 16'h0008, 1, 0, 0);

    // reset mid-run
    step(0, 0, 0, 16'h0000, 0, 1);
    step(0, 0, 1, 16'h0042, 0, 0);
    step(0, 0, 0, 16'h0000, 1, 0);
    step(0, 1, 0, 16'h0000, 0, 0);
    step(0, 1, 0, 16'h0000, 0, 0);  chk_out("pre_rst", 16'h0040, 1, 0, 0);
    step(1, 1, 0, 16'h0000, 0, 0);  chk_out("mid_rst", 16'h0000, 0, 0, 0);
    step(0, 1, 0, 16'h0000, 0, 0);
    step(0, 1, 0, 16'h0000, 0, 0);  chk_out("post_rst", 16'h0000, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable BCD down-counter for MM:SS time. It decrements one second per time-base strobe.
- Counterpart of the up-counting time counter: it counts down to zero and raises done instead of carrying upward.
- Sits after the 1 Hz strobe generator. Drives the display and alarm logic.

Parameters:
- MIN_TENS_MAX, 9, largest minutes-tens digit accepted at load and used as the borrow reload value.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- tick_i  in  1  one-cycle time-base strobe, one second
- load_i  in  1  load request
- load_val_i  in  16  BCD {m1,m0,s1,s0}, 4 bits per digit
- start_i  in  1  start or resume request
- pause_i  in  1  pause request
- time_o  out  16  current BCD value {m1,m0,s1,s0}, registered
- running_o  out  1  high while state is RUN
- done_o  out  1  one-cycle pulse when count reaches 00:00
- load_err_o  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Clocking: one clock; reset is synchronous and active-high. All state changes on the rising edge of clk.
- Reset values: state IDLE, time_o 0x0000, running_o 0, done_o 0, load_err_o 0. Reset mid-count aborts with no done pulse.
- States: IDLE, RUN, PAUSE, DONE.
- Per-cycle priority: rst > load_i > pause_i > start_i > tick_i.
- Load acceptance:
  - Accepted in IDLE, PAUSE and DONE. Ignored silently in RUN.
  - A valid load requires s0<=9, s1<=5, m0<=9, m1<=MIN_TENS_MAX.
  - Valid load: time_o = load_val_i after the edge; state -> IDLE.
  - Invalid load: time_o unchanged, state unchanged, load_err_o pulses on the following cycle.
- IDLE:
  - start_i with time!=0 -> RUN.
  - start_i with time==0 -> stay in IDLE; no done pulse.
  - tick_i is ignored.
- RUN:
  - tick_i decrements the count by one second.
  - Digit moduli: s0 9..0, s1 5..0, m0 9..0, m1 MIN_TENS_MAX..0.
  - Borrow chains s0 -> s1 -> m0 -> m1. A digit reloads its max value when it borrows.
  - A tick at 00:01 gives time 0000. In the same edge: state -> DONE, running_o 0, done_o 1 for exactly one cycle.
  - pause_i -> PAUSE. If tick_i arrives in the same cycle, the decrement is applied first, then the state moves to PAUSE.
  - start_i in RUN has no effect.
- PAUSE:
  - tick_i is ignored; time is held.
  - start_i -> RUN.
  - A valid load -> IDLE with the new value.
- DONE:
  - time_o holds 0000.
  - start_i has no effect.
  - A valid load -> IDLE.
- Latency:
  - start_i sampled at edge k: running_o is high after edge k.
  - A tick_i in the same cycle as start_i is not counted. The first counted tick is sampled at edge k+1 or later.
- Boundaries:
  - 00:00 is never decremented (no wrap to 99:59).
  - 10:00 -> 09:59 in a single tick.
  - tick_i held high continuously decrements once per cycle.

Decomposition:
- Shared package countdown_pkg holds:
  - state_e enum {IDLE, RUN, PAUSE, DONE}
  - BCD_W = 4
  - DIGIT_MAX = 9
  - SEC_TENS_MAX = 5
  - bcd_time_t packed struct {m1,m0,s1,s0}
- Sub-module bcd_down_digit, instantiated four times.
  - Parameter MAX.
  - Inputs: clk, rst, en_i, load_i, load_val_i.
  - Outputs: value_o, borrow_o.
  - borrow_o = en_i & (value_o==0), combinational, feeding the next digit's en_i.
- Top level owns the FSM, load validation and the done/err pulse registers.

Test Plan:
- Countdown to done: rst; load 0x0003; start; 3 ticks -> time_o 0002, 0001, 0000. done_o high exactly one cycle after the third tick. running_o then 0 and state DONE. A 4th tick leaves 0000.
- Multi-digit borrow: load 0x1000, start, 1 tick -> 0959. Load 0x0100, start, 1 tick -> 0059.
- Pause/resume: load 0x0100, start, 5 ticks -> 0055. pause_i + tick same cycle -> 0054 and PAUSE. 10 ticks -> still 0054. start, 1 tick -> 0053.
- Load rules: load 0x0060 -> load_err_o one pulse, time unchanged. Load 0x0200 during RUN -> ignored, count continues.
- Start edges: start with time 0000 -> stays IDLE, no done_o. Load 0x0005; start and tick same cycle -> 0005 held, next tick -> 0004.
- Reset mid-run: load 0x0042, start, 2 ticks -> 0040. rst one cycle -> time_o 0000, running_o 0, done_o 0. Subsequent ticks -> no change.
